qubit_measure: RTL and testbench

Single-qubit projective measurement unit in the computational basis. It accepts a Q8.8 complex amplitude pair (alpha, beta), typically straight from a gate stage such as the Hadamard block. It computes the Born probabilities and draws an outcome with an internal LFSR, then emits the outcome, the Q8.8 probability of |0>, and the collapsed basis state. It terminates a gate pipeline with a valid/ready handshake on both sides.

---
 rtl/qubit_measure.sv | 201 ++++++++++++++++++++
 tb/tb_qubit_measure.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/qubit_measure.sv
// Single-qubit computational-basis measurement: Born probabilities from Q8.8
// amplitudes, LFSR-driven outcome draw, collapsed state on a valid/ready output.
module qubit_measure #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] alpha_re,
  input  logic [15:0] alpha_im,
  input  logic [15:0] beta_re,
  input  logic [15:0] beta_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        outcome,
  output logic [15:0] prob0,
  output logic        zero_norm,
  output logic [15:0] out_alpha_re,
  output logic [15:0] out_alpha_im,
  output logic [15:0] out_beta_re,
  output logic [15:0] out_beta_im
);

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned TW = AW + 1;
  localparam int unsigned PW = W + TW;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MUL    = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  localparam logic [W-1:0] C_SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [W-1:0] C_POLY = 16'hB400;
  localparam logic [W-1:0] C_ONE  = 16'h0100;

  logic [1:0]    r_state, w_state_nxt;
  logic [1:0]    r_cnt, w_cnt_nxt;
  logic [W-1:0]  r_ar, r_ai, r_br, r_bi;
  logic [W-1:0]  w_ar_nxt, w_ai_nxt, w_br_nxt, w_bi_nxt;
  logic [W-1:0]  r_rand, w_rand_nxt;
  logic [W-1:0]  r_lfsr, w_lfsr_nxt;
  logic [AW-1:0] r_p0, r_p1, w_p0_nxt, w_p1_nxt;
  logic          r_in_ready, w_in_ready_nxt;
  logic          r_out_valid, w_out_valid_nxt;
  logic          r_outcome, w_outcome_nxt;
  logic [W-1:0]  r_prob0, w_prob0_nxt;
  logic          r_zero, w_zero_nxt;
  logic [W-1:0]  r_oar, r_oai, r_obr, r_obi;
  logic [W-1:0]  w_oar_nxt, w_oai_nxt, w_obr_nxt, w_obi_nxt;

  // Shared squarer: operand selected by the MUL step counter
  logic signed [W-1:0]  w_op;
  logic signed [AW-1:0] w_op_ext;
  logic signed [AW-1:0] w_sq;
  logic [AW-1:0]        w_sq_u;
  logic [TW-1:0]        w_total;
  logic [PW-1:0]        w_prod;
  logic [TW-1:0]        w_t;
  logic                 w_draw;
  logic [W-1:0]         w_lfsr_step;

  always_comb begin
    case (r_cnt)
      2'd0:    w_op = $signed(r_ar);
      2'd1:    w_op = $signed(r_ai);
      2'd2:    w_op = $signed(r_br);
      default: w_op = $signed(r_bi);
    endcase
  end

  assign w_op_ext    = AW'(w_op);
  assign w_sq        = w_op_ext * w_op_ext;
  assign w_sq_u      = w_sq;
  assign w_total     = {1'b0, r_p0} + {1'b0, r_p1};
  assign w_prod      = PW'(r_rand) * PW'(w_total);
  assign w_t         = TW'(w_prod >> W);
  assign w_draw      = (w_t < {1'b0, r_p0}) ? 1'b0 : 1'b1;
  assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? C_POLY : 16'h0000);

  // Next-state and datapath updates
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_ar_nxt        = r_ar;
    w_ai_nxt        = r_ai;
    w_br_nxt        = r_br;
    w_bi_nxt        = r_bi;
    w_rand_nxt      = r_rand;
    w_lfsr_nxt      = r_lfsr;
    w_p0_nxt        = r_p0;
    w_p1_nxt        = r_p1;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_outcome_nxt   = r_outcome;
    w_prob0_nxt     = r_prob0;
    w_zero_nxt      = r_zero;
    w_oar_nxt       = r_oar;
    w_oai_nxt       = r_oai;
    w_obr_nxt       = r_obr;
    w_obi_nxt       = r_obi;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_ar_nxt       = alpha_re;
          w_ai_nxt       = alpha_im;
          w_br_nxt       = beta_re;
          w_bi_nxt       = beta_im;
          w_rand_nxt     = r_lfsr;
          w_lfsr_nxt     = w_lfsr_step;
          w_p0_nxt       = '0;
          w_p1_nxt       = '0;
          w_cnt_nxt      = 2'd0;
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = S_MUL;
        end
      end
      S_MUL: begin
        if (r_cnt[1]) w_p1_nxt = r_p1 + w_sq_u;
        else          w_p0_nxt = r_p0 + w_sq_u;
        w_cnt_nxt = r_cnt + 2'd1;
        if (r_cnt == 2'd3) w_state_nxt = S_DECIDE;
      end
      S_DECIDE: begin
        w_zero_nxt      = (w_total == '0);
        w_outcome_nxt   = (w_total == '0) ? 1'b0 : w_draw;
        w_prob0_nxt     = (r_p0[31:24] != 8'h00) ? 16'hFFFF : r_p0[23:8];
        w_oar_nxt       = w_outcome_nxt ? 16'h0000 : C_ONE;
        w_oai_nxt       = 16'h0000;
        w_obr_nxt       = w_outcome_nxt ? C_ONE : 16'h0000;
        w_obi_nxt       = 16'h0000;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_OUT;
      end
      default: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_ar        <= '0;
      r_ai        <= '0;
      r_br        <= '0;
      r_bi        <= '0;
      r_rand      <= '0;
      r_lfsr      <= C_SEED;
      r_p0        <= '0;
      r_p1        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_outcome   <= 1'b0;
      r_prob0     <= '0;
      r_zero      <= 1'b0;
      r_oar       <= '0;
      r_oai       <= '0;
      r_obr       <= '0;
      r_obi       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ar        <= w_ar_nxt;
      r_ai        <= w_ai_nxt;
      r_br        <= w_br_nxt;
      r_bi        <= w_bi_nxt;
      r_rand      <= w_rand_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_p0        <= w_p0_nxt;
      r_p1        <= w_p1_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_outcome   <= w_outcome_nxt;
      r_prob0     <= w_prob0_nxt;
      r_zero      <= w_zero_nxt;
      r_oar       <= w_oar_nxt;
      r_oai       <= w_oai_nxt;
      r_obr       <= w_obr_nxt;
      r_obi       <= w_obi_nxt;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign outcome      = r_outcome;
  assign prob0        = r_prob0;
  assign zero_norm    = r_zero;
  assign out_alpha_re = r_oar;
  assign out_alpha_im = r_oai;
  assign out_beta_re  = r_obr;
  assign out_beta_im  = r_obi;

endmodule

// File: tb/tb_qubit_measure.sv
// Self-checking bench for qubit_measure: fixed vectors, backpressure, reset
// corner cases and a long LFSR-driven run against an arithmetic reference model.
module tb_qubit_measure;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] alpha_re, alpha_im, beta_re, beta_im;
  logic        out_valid, out_ready;
  logic        outcome;
  logic [15:0] prob0;
  logic        zero_norm;
  logic [15:0] out_alpha_re, out_alpha_im, out_beta_re, out_beta_im;

  int n_err = 0;
  int n_checks = 0;
  logic [15:0] m_lfsr;

  qubit_measure #(.LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alpha_re(alpha_re), .alpha_im(alpha_im), .beta_re(beta_re), .beta_im(beta_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .outcome(outcome), .prob0(prob0), .zero_norm(zero_norm),
    .out_alpha_re(out_alpha_re), .out_alpha_im(out_alpha_im),
    .out_beta_re(out_beta_re), .out_beta_im(out_beta_im)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Born-rule reference: probabilities as plain integers, draw against r/65536
  function automatic void ref_model(input logic [15:0] r, input logic [15:0] ar, ai, br, bi,
                                    output logic o, output logic [15:0] pq, output logic z);
    longint a_r, a_i, b_r, b_i, p0, p1, total, t;
    a_r = longint'($signed(ar));
    a_i = longint'($signed(ai));
    b_r = longint'($signed(br));
    b_i = longint'($signed(bi));
    p0 = a_r * a_r + a_i * a_i;
    p1 = b_r * b_r + b_i * b_i;
    total = p0 + p1;
    t = (longint'(r) * total) / 65536;
    z = (total == 0);
    o = (total == 0) ? 1'b0 : ((t < p0) ? 1'b0 : 1'b1);
    pq = (p0 >= 64'd16777216) ? 16'hFFFF : 16'(p0 / 256);
  endfunction

  task automatic run_meas(input logic [15:0] ar, ai, br, bi, input int hold,
                          output logic got_o, output logic [15:0] got_p, output logic got_z);
    logic e_o, e_z;
    logic [15:0] e_p;
    int guard, lat;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    chk("wait_in_ready", 64'(guard < 20), 64'd1);
    in_valid = 1'b1;
    alpha_re = ar; alpha_im = ai; beta_re = br; beta_im = bi;
    ref_model(m_lfsr, ar, ai, br, bi, e_o, e_p, e_z);
    m_lfsr = lfsr_next(m_lfsr);
    @(posedge clk); #1;
    in_valid = 1'b0;
    alpha_re = 16'($urandom); alpha_im = 16'($urandom);
    beta_re = 16'($urandom); beta_im = 16'($urandom);
    chk("busy_after_accept", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 12) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'd5);
    chk("outcome", 64'(outcome), 64'(e_o));
    chk("prob0", 64'(prob0), 64'(e_p));
    chk("zero_norm", 64'(zero_norm), 64'(e_z));
    chk("out_alpha_re", 64'(out_alpha_re), e_o ? 64'h0 : 64'h0100);
    chk("out_alpha_im", 64'(out_alpha_im), 64'h0);
    chk("out_beta_re", 64'(out_beta_re), e_o ? 64'h0100 : 64'h0);
    chk("out_beta_im", 64'(out_beta_im), 64'h0);
    got_o = outcome; got_p = prob0; got_z = zero_norm;
    if (hold > 0) in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_outcome", 64'(outcome), 64'(e_o));
      chk("hold_prob0", 64'(prob0), 64'(e_p));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_valid", 64'(out_valid), 64'd0);
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
  endtask

  typedef struct {
    string       name;
    logic [15:0] ar, ai, br, bi;
    logic        e_o;
    logic [15:0] e_p;
    logic        e_z;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic g_o, g_z, first_o, h_o;
    logic [15:0] g_p;
    int zeros, guard;

    vecs[0] = '{"ket0",       16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0100, 1'b0};
    vecs[1] = '{"ket1",       16'h0000, 16'h0000, 16'h0100, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[2] = '{"zero_vec",   16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{"neg_ket0",   16'hFF00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0100, 1'b0};
    vecs[4] = '{"i_ket0",     16'h0000, 16'h0100, 16'h0000, 16'h0000, 1'b0, 16'h0100, 1'b0};
    vecs[5] = '{"i_ket1",     16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b1, 16'h0000, 1'b0};
    vecs[6] = '{"sat_max",    16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
    vecs[7] = '{"sat_min",    16'h0000, 16'h8000, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
    vecs[8] = '{"small_a",    16'h0010, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alpha_re = '0; alpha_im = '0; beta_re = '0; beta_im = '0;
    m_lfsr = SEED;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outcome", 64'(outcome), 64'd0);
    chk("rst_prob0", 64'(prob0), 64'd0);
    chk("rst_zero_norm", 64'(zero_norm), 64'd0);
    chk("rst_amps", {out_alpha_re, out_alpha_im, out_beta_re, out_beta_im}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // First superposition draw after power-up is the reference for the reset test
    run_meas(16'h00B5, 16'h0000, 16'h00B5, 16'h0000, 0, first_o, g_p, g_z);
    chk("hadamard_prob0", 64'(g_p), 64'h007F);
    chk("hadamard_first_outcome", 64'(first_o), 64'd1);

    for (int i = 0; i < 9; i++) begin
      run_meas(vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi, (i == 1) ? 10 : 0, g_o, g_p, g_z);
      chk({vecs[i].name, "_outcome"}, 64'(g_o), 64'(vecs[i].e_o));
      chk({vecs[i].name, "_prob0"}, 64'(g_p), 64'(vecs[i].e_p));
      chk({vecs[i].name, "_zero"}, 64'(g_z), 64'(vecs[i].e_z));
    end

    for (int i = 0; i < 150; i++)
      run_meas(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               int'($urandom_range(0, 3)), g_o, g_p, g_z);

    zeros = 0;
    for (int i = 0; i < 1000; i++) begin
      run_meas(16'h00B5, 16'h0000, 16'h00B5, 16'h0000, 0, h_o, g_p, g_z);
      if (h_o == 1'b0) zeros++;
    end
    chk("hadamard_zero_count_in_range", 64'(zeros >= 450 && zeros <= 550), 64'd1);

    // Reset mid-MUL (cnt=2) with in_valid held high during reset
    @(negedge clk);
    in_valid = 1'b1;
    alpha_re = 16'h00B5; alpha_im = '0; beta_re = 16'h00B5; beta_im = '0;
    @(posedge clk); @(posedge clk); @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("rst_mid_mul_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_mul_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    m_lfsr = SEED;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_stale_result", 64'(out_valid), 64'd0);
    end
    run_meas(16'h00B5, 16'h0000, 16'h00B5, 16'h0000, 0, g_o, g_p, g_z);
    chk("lfsr_reloaded_same_outcome", 64'(g_o), 64'(first_o));

    // Reset while a result is waiting in OUT
    @(negedge clk);
    in_valid = 1'b1;
    alpha_re = 16'h0100; alpha_im = '0; beta_re = '0; beta_im = '0;
    @(posedge clk); #1; in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 12) begin @(posedge clk); #1; guard++; end
    chk("out_reached_before_rst", 64'(out_valid), 64'd1);
    #2; rst = 1'b1; #1;
    chk("rst_in_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_out_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst = 1'b0;
    m_lfsr = SEED;
    run_meas(16'h00B5, 16'h0000, 16'h00B5, 16'h0000, 2, g_o, g_p, g_z);
    chk("after_out_rst_same_outcome", 64'(g_o), 64'(first_o));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
